// File: rtl/cube_state_ram.sv
// cube_state_ram: per-sticker colour memory for all cube faces, with written-tracking and a self-timed zero-fill sweep
//   clk, clear_n (async, active-low)     clock and reset
//   init                                 start a zero-fill sweep (sampled while idle)
//   we, re, face, addr_line, addr_column, data   write/read access
//   q, q_valid                           registered read data and its one-cycle qualifier
//   busy                                 sweep in progress, accesses ignored
//   err                                  one-cycle pulse for a rejected access
//   face_full, all_full                  every sticker of a face / of all faces written since the last sweep
//   Build option CUBE_STATE_RAM_LOCK_EN: an already-written sticker rejects rewrites until the next sweep.
module cube_state_ram #(
  parameter int FACES    = 6,
  parameter int LINES    = 3,
  parameter int COLUMNS  = 3,
  parameter int S_DATA   = 3,
  parameter int S_FACE   = 3,
  parameter int S_LINE   = 2,
  parameter int S_COLUMN = 2
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                init,
  input  logic                we,
  input  logic                re,
  input  logic [S_FACE-1:0]   face,
  input  logic [S_LINE-1:0]   addr_line,
  input  logic [S_COLUMN-1:0] addr_column,
  input  logic [S_DATA-1:0]   data,
  output logic [S_DATA-1:0]   q,
  output logic                q_valid,
  output logic                busy,
  output logic                err,
  output logic [FACES-1:0]    face_full,
  output logic                all_full
);
  localparam int FACE_SZ = LINES * COLUMNS;
  localparam int DEPTH   = FACES * FACE_SZ;
  localparam int S_IDX   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [S_IDX-1:0] LAST = S_IDX'(DEPTH - 1);
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;
  state_t              state_q, state_d;
  logic [S_IDX-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0]    written_q, written_d;
  logic [S_DATA-1:0]   q_q, q_d;
  logic                q_valid_q, q_valid_d;
  logic                err_q, err_d;
  logic [S_DATA-1:0]   mem [DEPTH];
  logic [S_IDX-1:0]    idx, mem_idx;
  logic [S_DATA-1:0]   mem_wd;
  logic                in_range, lock_hit, sweeping, acc, wr_req, rd_req, wr_do, rd_do, mem_we;
  assign in_range = ({1'b0, face} < (S_FACE + 1)'(FACES)) &&
                    ({1'b0, addr_line} < (S_LINE + 1)'(LINES)) &&
                    ({1'b0, addr_column} < (S_COLUMN + 1)'(COLUMNS));
  assign idx = S_IDX'(face) * S_IDX'(FACE_SZ) + S_IDX'(addr_line) * S_IDX'(COLUMNS) + S_IDX'(addr_column);
`ifdef CUBE_STATE_RAM_LOCK_EN
  assign lock_hit = in_range && written_q[idx];
`else
  assign lock_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) state_q <= SWEEP;
    else          state_q <= state_d;
  always_comb begin
    state_d = (state_q == SWEEP) ? ((cnt_q == LAST) ? IDLE : SWEEP) : (init ? SWEEP : IDLE);
    cnt_d   = (state_q == SWEEP && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
  end
  // init wins over a same-cycle access, which is then silently dropped
  always_comb begin
    sweeping = (state_q == SWEEP);
    busy     = sweeping;
    acc      = !sweeping && !init;
    wr_req   = acc && we;
    rd_req   = acc && re;
    wr_do    = wr_req && in_range && !lock_hit;
    rd_do    = rd_req && in_range;
    err_d    = (wr_req && (!in_range || lock_hit)) || (rd_req && !in_range);
    q_valid_d = rd_do;
    q_d      = (state_d == SWEEP) ? '0 : (rd_do ? mem[idx] : q_q);
    mem_we   = sweeping || wr_do;
    mem_idx  = sweeping ? cnt_q : idx;
    mem_wd   = sweeping ? '0 : data;
  end
  always_comb begin
    written_d = written_q;
    if (sweeping) written_d[cnt_q] = 1'b0;
    if (wr_do) written_d[idx] = 1'b1;
  end
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      cnt_q     <= '0;
      written_q <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      written_q <= written_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      err_q     <= err_d;
    end
  // storage is not reset; the sweep after reset zeroes it
  always_ff @(posedge clk)
    if (mem_we) mem[mem_idx] <= mem_wd;
  for (genvar f = 0; f < FACES; f++) begin : g_full
    assign face_full[f] = &written_q[f*FACE_SZ +: FACE_SZ];
  end
  assign all_full = &face_full;
  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign err      = err_q;
endmodule

// File: doc/cube_state_ram.md
# cube_state_ram

Parametrised multi-face colour memory for the cube solver datapath. It stores one colour code per sticker for every cube face. It also tracks which stickers have been written since the last initialisation and zero-fills the whole array with a self-timed sweep after reset or on request. It sits between the frame/colour classifier, which writes stickers, and the solver FSM, which reads stickers and waits on `all_full`.

## Interface
Parameters:
- `FACES`, 6, number of faces stored
- `LINES`, 3, sticker rows per face
- `COLUMNS`, 3, sticker columns per face
- `S_DATA`, 3, colour code width
- `S_FACE`, 3, face address width
- `S_LINE`, 2, line address width
- `S_COLUMN`, 2, column address width

Ports:
- `clk`  in  1  single clock, rising edge
- `clear_n`  in  1  reset, asynchronous, active-low
- `init`  in  1  request a zero-fill sweep; sampled when idle
- `we`  in  1  write strobe
- `re`  in  1  read strobe
- `face`  in  S_FACE  face address
- `addr_line`  in  S_LINE  line address
- `addr_column`  in  S_COLUMN  column address
- `data`  in  S_DATA  write data
- `q`  out  S_DATA  registered read data
- `q_valid`  out  1  one-cycle pulse qualifying `q`
- `busy`  out  1  sweep in progress; all accesses ignored
- `err`  out  1  one-cycle pulse flagging a rejected access
- `face_full`  out  FACES  bit f is set when every sticker of face f has been written since the last sweep
- `all_full`  out  1  AND of `face_full`

## Operation
- DEPTH = FACES*LINES*COLUMNS. Linear index = face*LINES*COLUMNS + addr_line*COLUMNS + addr_column.
- Storage array of DEPTH words plus a DEPTH-bit `written` bitmap.
- FSM states:
  - SWEEP: a counter runs 0..DEPTH-1. Each cycle it writes 0 to the current word and clears its `written` bit. `busy`=1.
  - IDLE: `busy`=0.
- Transitions:
  - Reset drives the FSM to SWEEP with the counter at 0.
  - SWEEP moves to IDLE after the cycle that writes index DEPTH-1.
  - IDLE moves to SWEEP when `init`=1. `init` takes priority over `we` and `re` in the same cycle; that access is dropped without `err`.
  - `init` during SWEEP is ignored. The sweep does not restart.
- Address check:
  - An access is out of range if `face`>=FACES, `addr_line`>=LINES or `addr_column`>=COLUMNS.
  - An out-of-range access is not performed and pulses `err` next cycle.
  - A rejected read produces no `q_valid`.
- Write, in IDLE with `we`=1 and the address in range: the word takes `data` and its `written` bit is set.
- Read, in IDLE with `re`=1 and the address in range: `q` takes the word and `q_valid` pulses, both on the next edge.
- Read and write to the same index in the same cycle: the read returns the old data (read-first).
- `q` holds its last value between reads. `q` is forced to 0 during a sweep.
- `we` or `re` while `busy`=1: ignored, with no `err` and no `q_valid`.
- `face_full` and `all_full` are combinational from the `written` bitmap.

## Timing
- Reset values: `q`=0, `q_valid`=0, `err`=0, `busy`=1, `face_full`=0, `all_full`=0.
- Reset sets the FSM to SWEEP, the counter to 0 and clears the bitmap. Array contents are not reset; the sweep zeroes them.
- A sweep lasts exactly DEPTH cycles, 54 with defaults. `busy` falls on the edge after index DEPTH-1 is written.
- An `init` sampled at edge N gives `busy`=1 from N through N+DEPTH.
- Read latency is 1 cycle. Write becomes visible to a read issued in the following cycle.
- `err` and `q_valid` are single-cycle pulses registered one edge after the access.
- Back-to-back accesses are allowed every cycle.
- `clear_n` asserted mid-sweep or mid-access aborts immediately. A full sweep restarts after deassertion.

## Configuration
- `CUBE_STATE_RAM_LOCK_EN` defined:
  - A write to an in-range index whose `written` bit is already 1 is rejected.
  - The word is unchanged and `err` pulses.
  - Only a sweep unlocks the index.
- `CUBE_STATE_RAM_LOCK_EN` undefined:
  - Rewrites overwrite freely with no `err`.
  - `face_full` stays set once all of a face's bits are set.

## Test plan
- Release `clear_n`, hold idle -> `busy`=1 for 54 cycles then 0; reading every index returns 0 with `q_valid` one cycle after each `re`.
- Write face 2, line 1, column 2 with `data`=5, then read the same address next cycle -> `q`=5 with `q_valid` one cycle later; `face_full`=0.
- Write all 9 stickers of face 0, then the other 5 faces -> `face_full[0]`=1 after the 9th write; `all_full`=1 only after write 54.
- Write with `addr_line`=3 and read with `face`=6 -> `err` pulses each time, no `q_valid`, array unchanged; write with `init`=1 in the same cycle -> sweep starts, no `err`.
- Pulse `init` with the array full, then issue `we` and `re` during `busy` -> ignored; after 54 cycles everything reads 0 and `face_full`=0.
- With `CUBE_STATE_RAM_LOCK_EN`: write 3 then 4 to the same index -> second write gives `err`, read returns 3. Without the macro -> read returns 4, no `err`.
